// File: rtl/moving_sum_shift_div.sv
// Divide a signed running sum by 2^shift with round-half-up and saturation to OUT_WIDTH bits.
// Optional saturation-event counter enabled by `define MOVING_SUM_SHIFT_DIV_SAT_CNT_EN.
module moving_sum_shift_div #(
  parameter int unsigned IN_WIDTH  = 24,
  parameter int unsigned OUT_WIDTH = 16,
  parameter int unsigned SHIFT_W   = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear,
  input  logic [SHIFT_W-1:0]   shift,
  input  logic [IN_WIDTH-1:0]  i_tdata,
  input  logic                 i_tlast,
  input  logic                 i_tvalid,
  output logic                 i_tready,
  output logic [OUT_WIDTH-1:0] o_tdata,
  output logic                 o_tlast,
  output logic                 o_tvalid,
  input  logic                 o_tready,
  output logic [15:0]          sat_count
);

  localparam int unsigned SumW     = IN_WIDTH + 1;
  localparam int unsigned MaxShift = IN_WIDTH - 1;

  localparam logic signed [SumW-1:0] SatMax =
    SumW'((64'd1 << (OUT_WIDTH - 1)) - 64'd1);
  localparam logic signed [SumW-1:0] SatMin = ~SatMax;

  localparam logic [OUT_WIDTH-1:0] OutMax = {1'b0, {(OUT_WIDTH - 1){1'b1}}};
  localparam logic [OUT_WIDTH-1:0] OutMin = {1'b1, {(OUT_WIDTH - 1){1'b0}}};

  // Pipeline registers
  logic                   s1_valid_q, s1_valid_d;
  logic signed [SumW-1:0] s1_data_q, s1_data_d;
  logic                   s1_last_q, s1_last_d;
  logic                   s2_valid_q, s2_valid_d;
  logic [OUT_WIDTH-1:0]   s2_data_q, s2_data_d;
  logic                   s2_last_q, s2_last_d;

  // Handshake
  logic s1_advance;
  logic s1_load;
  logic s2_load;

  always_comb begin
    s1_advance = !s2_valid_q || o_tready;
    i_tready   = !reset && !clear && (!s1_valid_q || s1_advance);
    s1_load    = i_tvalid && i_tready;
    s2_load    = s1_valid_q && s1_advance;
  end

  // Stage 1 datapath: clamp shift, add half an LSB, arithmetic shift.
  // Rounding at acceptance time is what pins each sample to the shift seen with it.
  int unsigned            shift_sat;
  logic signed [SumW-1:0] sum_ext;
  logic signed [SumW-1:0] round_bias;
  logic signed [SumW-1:0] round_sum;
  logic signed [SumW-1:0] round_q;

  always_comb begin
    shift_sat = 32'(shift);
    if (shift_sat > MaxShift) begin
      shift_sat = MaxShift;
    end
    sum_ext    = {i_tdata[IN_WIDTH-1], i_tdata};
    round_bias = '0;
    if (shift_sat != 0) begin
      round_bias = SumW'(1) << (shift_sat - 1);
    end
    round_sum = sum_ext + round_bias;
    round_q   = round_sum >>> shift_sat;
  end

  // Stage 2 datapath: saturate the rounded quotient to the output range
  logic                 clamp_hi;
  logic                 clamp_lo;
  logic [OUT_WIDTH-1:0] sat_value;

  always_comb begin
    clamp_hi  = s1_data_q > SatMax;
    clamp_lo  = s1_data_q < SatMin;
    sat_value = s1_data_q[OUT_WIDTH-1:0];
    if (clamp_hi) begin
      sat_value = OutMax;
    end else if (clamp_lo) begin
      sat_value = OutMin;
    end
  end

  // Next-state
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_data_d  = s1_data_q;
    s1_last_d  = s1_last_q;
    if (s1_load) begin
      s1_valid_d = 1'b1;
      s1_data_d  = round_q;
      s1_last_d  = i_tlast;
    end else if (s1_advance) begin
      s1_valid_d = 1'b0;
    end

    s2_valid_d = s2_valid_q;
    s2_data_d  = s2_data_q;
    s2_last_d  = s2_last_q;
    if (s2_load) begin
      s2_valid_d = 1'b1;
      s2_data_d  = sat_value;
      s2_last_d  = s1_last_q;
    end else if (o_tready) begin
      s2_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      s1_last_q  <= 1'b0;
      s2_valid_q <= 1'b0;
      s2_data_q  <= '0;
      s2_last_q  <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_data_q  <= s1_data_d;
      s1_last_q  <= s1_last_d;
      s2_valid_q <= s2_valid_d;
      s2_data_q  <= s2_data_d;
      s2_last_q  <= s2_last_d;
    end
  end

  assign o_tvalid = s2_valid_q;
  assign o_tdata  = s2_data_q;
  assign o_tlast  = s2_last_q;

`ifdef MOVING_SUM_SHIFT_DIV_SAT_CNT_EN
  logic [15:0] sat_count_q, sat_count_d;

  // Counts clamped loads into stage 2, sticking at all-ones
  always_comb begin
    sat_count_d = sat_count_q;
    if (s2_load && (clamp_hi || clamp_lo) && (sat_count_q != 16'hFFFF)) begin
      sat_count_d = sat_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      sat_count_q <= '0;
    end else begin
      sat_count_q <= sat_count_d;
    end
  end

  assign sat_count = sat_count_q;
`else
  assign sat_count = '0;
`endif

endmodule
